awhhoh_beat_sequencer: RTL
==========================

Name: awhhoh_beat_sequencer

Overview:
Upstream stage of awhhoh_harmony_player, and of any melody player sharing the same step index. It divides CLOCK_50 into song steps and drives the 8-bit beats index from 0 to SONG_LEN-1. It provides play, pause, stop and loop control, tempo selection, and a per-step articulation gate, so that repeated notes re-attack audibly.

Parameters:
BEAT_TICKS, 6250000, CLOCK_50 cycles per step at normal tempo (8 steps/s); must be even and > 2*GAP_TICKS
GAP_TICKS, 500000, cycles at the end of each step during which note_gate is low
SONG_LEN, 168, number of steps; legal range 2..255

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin, or restart, from step 0
stop  in  1  single-cycle pulse: abort to idle
pause  in  1  level: freeze playback while high
loop_en  in  1  level: wrap to step 0 instead of finishing
tempo_sel  in  2  00 normal, 01 half speed, 10 double speed, 11 normal
beats  out  8  current step index, fed to the player's beats input
note_gate  out  1  high while the current note should sound
beat_strobe  out  1  one-cycle pulse on each step entry
playing  out  1  high in PLAY or PAUSE
song_done  out  1  one-cycle pulse when the last step completes with loop_en low

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is asynchronous and active-low on resetn. All flops clear immediately when resetn is low.
- Reset values: state=IDLE, beats=0, tick counter=0, note_gate=0, beat_strobe=0, playing=0, song_done=0, latched period=BEAT_TICKS.
- States and transitions:
  - IDLE: beats=0, note_gate=0. start -> PLAY.
  - PLAY: tick counter increments every cycle.
  - PLAY, pause high -> PAUSE. The counter, beats and note_gate hold their values.
  - PAUSE, pause low -> PLAY, resuming on the next cycle with no lost or extra tick.
  - DONE: beats=SONG_LEN, which the player maps to silence; note_gate=0; playing=0. start -> PLAY.
  - Any state, stop -> IDLE on the next edge.
- Control priority: stop > start > pause. start in PLAY or PAUSE restarts at step 0 with the counter cleared.
- Step timing:
  - Period P is latched on entry to PLAY and at every step boundary: BEAT_TICKS for 00/11, 2*BEAT_TICKS for 01, BEAT_TICKS/2 for 10. A tempo change mid-step takes effect at the next step.
  - Step boundary: when the counter equals P-1 in PLAY, the counter goes to 0 and beats increments.
  - When beats=SONG_LEN-1 at a boundary: if loop_en is high, beats goes to 0 and beat_strobe fires; otherwise go to DONE and pulse song_done.
- Articulation gate: note_gate = (state==PLAY or PAUSE) and counter < P-GAP_TICKS. It is registered, so it is valid in the same cycle as beats.
- beat_strobe:
  - Asserted in the first cycle that a new beats value is visible.
  - This includes step 0 after start or a loop wrap.
  - Never asserted during PAUSE.
- Latency: start seen at edge N -> beats=0, note_gate=1, beat_strobe=1, playing=1 after edge N.
- Widths: tick counter is ceil(log2(2*BEAT_TICKS)) bits. beats is 8 bits and never exceeds SONG_LEN.
- Reset mid-operation: immediate return to the IDLE values listed above. No pending start or pulse survives reset.

Decomposition:
- Shared package awhhoh_pkg:
  - seq_state enum (IDLE, PLAY, PAUSE, DONE)
  - TEMPO_NORMAL/HALF/DOUBLE codes
  - AWHHOH_SONG_LEN=168, shared with the player's silent range
- Sub-module awhhoh_tempo_divider:
  - Holds the tick counter and the period latch.
  - Inputs: enable, clear, tempo_sel, gap.
  - Outputs: step_tick and gate_open.
- The top level holds the FSM and the beats register.

Test Plan (BEAT_TICKS=4, GAP_TICKS=1, SONG_LEN=6):
- Start with tempo 00 and loop_en=0 -> beats steps 0,1,2,3,4,5 every 4 cycles; note_gate pattern 1,1,1,0 per step; song_done pulses once; beats=6 after that, playing=0.
- Start with loop_en=1 -> after step 5, beats=0 with beat_strobe=1 and no song_done; continues for 3 loops.
- Pause high for 10 cycles in step 2 at counter=1 -> beats, note_gate and counter frozen, no strobe; on release, step 3 arrives exactly 3 cycles later.
- tempo_sel 01 set mid-step 1 -> step 1 still lasts 4 cycles, step 2 lasts 8 with note_gate low only in its last cycle; tempo 10 -> 2-cycle steps.
- start and stop asserted in the same cycle during PLAY -> IDLE, beats=0; start alone in PAUSE at step 4 -> beats=0 with beat_strobe.
- resetn low asynchronously mid-step 3 (between edges) -> outputs reach reset values before the next edge; after release, beats stays 0 until start.

Source files
------------

// File: rtl/awhhoh_pkg.sv
// Shared definitions for the awhhoh sequencer and player: state encoding,
// tempo codes and the song length that the player treats as silence.
package awhhoh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_HALF   = 2'b01;
  localparam logic [1:0] TEMPO_DOUBLE = 2'b10;

  localparam int AWHHOH_SONG_LEN = 168;

  // A song is "in progress" in PLAY and PAUSE; both keep the step position.
  function automatic logic is_active(input seq_state s);
    return (s == PLAY) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/awhhoh_tempo_divider.sv
// Step timer: counts clock cycles within a step, latches the step period
// from the tempo code at each step start, and reports the step boundary and
// whether the articulation gate is open for the upcoming cycle.
module awhhoh_tempo_divider
  import awhhoh_pkg::*;
#(
  parameter int BEAT_TICKS = 6250000,
  parameter int CW         = $clog2(2 * BEAT_TICKS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          clear,
  input  logic [1:0]    tempo_sel,
  input  logic [CW-1:0] gap,
  output logic          step_tick,
  output logic          gate_open
);

  // One extra bit so the half-speed period itself is representable.
  localparam int PW = CW + 1;
  localparam logic [PW-1:0] P_NORMAL = PW'(BEAT_TICKS);
  localparam logic [PW-1:0] P_HALF   = PW'(2 * BEAT_TICKS);
  localparam logic [PW-1:0] P_DOUBLE = PW'(BEAT_TICKS / 2);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] period_reg, period_next, period_sel;

  // Tempo code to step period; the unused code plays at normal speed.
  always_comb begin
    case (tempo_sel)
      TEMPO_NORMAL: period_sel = P_NORMAL;
      TEMPO_HALF:   period_sel = P_HALF;
      TEMPO_DOUBLE: period_sel = P_DOUBLE;
      default:      period_sel = P_NORMAL;
    endcase
  end

  // Counter/period next state; the gate is judged on the next values so the
  // registered note_gate lines up with the registered beats index.
  always_comb begin
    cnt_next    = cnt_reg;
    period_next = period_reg;
    step_tick   = 1'b0;
    if (clear) begin
      cnt_next    = '0;
      period_next = period_sel;
    end else if (enable) begin
      if ({1'b0, cnt_reg} == (period_reg - PW'(1))) begin
        step_tick   = 1'b1;
        cnt_next    = '0;
        period_next = period_sel;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
    gate_open = ({1'b0, cnt_next} < (period_next - {1'b0, gap}));
  end

  // Counter and period registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg    <= '0;
      period_reg <= P_NORMAL;
    end else begin
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
    end
  end

endmodule

// File: rtl/awhhoh_beat_sequencer.sv
// Song step sequencer: play/pause/stop/loop control over an 8-bit step
// index, with a per-step articulation gate and a strobe on each step entry.
module awhhoh_beat_sequencer
  import awhhoh_pkg::*;
#(
  parameter int BEAT_TICKS = 6250000,
  parameter int GAP_TICKS  = 500000,
  parameter int SONG_LEN   = AWHHOH_SONG_LEN
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [7:0] beats,
  output logic       note_gate,
  output logic       beat_strobe,
  output logic       playing,
  output logic       song_done
);

  localparam int CW = $clog2(2 * BEAT_TICKS);
  localparam logic [7:0] LAST_STEP = 8'(SONG_LEN - 1);
  localparam logic [7:0] DONE_IDX  = 8'(SONG_LEN);

  seq_state   state_reg, state_next;
  logic [7:0] beats_reg, beats_next;
  logic       gate_reg, strobe_reg, strobe_next;
  logic       playing_reg, done_reg, done_next;
  logic       tick_enable, step_tick, gate_open;

  // The counter only advances in an active state with pause low; start and
  // stop restart it instead. The cycle leaving PAUSE counts, the cycle
  // entering it does not, so a pause delays the song by exactly its length.
  assign tick_enable = is_active(state_reg) && !pause && !start && !stop;

  awhhoh_tempo_divider #(
    .BEAT_TICKS(BEAT_TICKS),
    .CW        (CW)
  ) u_divider (
    .clk      (CLOCK_50),
    .resetn   (resetn),
    .enable   (tick_enable),
    .clear    (start | stop),
    .tempo_sel(tempo_sel),
    .gap      (CW'(GAP_TICKS)),
    .step_tick(step_tick),
    .gate_open(gate_open)
  );

  // Next state, step index and pulses; stop beats start beats pause.
  always_comb begin
    state_next  = state_reg;
    beats_next  = beats_reg;
    strobe_next = 1'b0;
    done_next   = 1'b0;
    if (stop) begin
      state_next = IDLE;
      beats_next = '0;
    end else if (start) begin
      state_next  = PLAY;
      beats_next  = '0;
      strobe_next = 1'b1;
    end else begin
      case (state_reg)
        PLAY, PAUSE: begin
          state_next = pause ? PAUSE : PLAY;
          if (step_tick) begin
            if (beats_reg == LAST_STEP) begin
              if (loop_en) begin
                beats_next  = '0;
                strobe_next = 1'b1;
              end else begin
                state_next = DONE;
                beats_next = DONE_IDX;
                done_next  = 1'b1;
              end
            end else begin
              beats_next  = beats_reg + 8'd1;
              strobe_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      beats_reg   <= '0;
      gate_reg    <= 1'b0;
      strobe_reg  <= 1'b0;
      playing_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      beats_reg   <= beats_next;
      gate_reg    <= is_active(state_next) && gate_open;
      strobe_reg  <= strobe_next;
      playing_reg <= is_active(state_next);
      done_reg    <= done_next;
    end
  end

  assign beats       = beats_reg;
  assign note_gate   = gate_reg;
  assign beat_strobe = strobe_reg;
  assign playing     = playing_reg;
  assign song_done   = done_reg;

endmodule
